// File: rtl/spi_adc_pkg.sv
// Shared constants, FSM state type and frame formatting for the SPI ADC responder.
package spi_adc_pkg;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 3;
    localparam int SAMPLE_W   = 8;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Place the sample after the leading zeros, MSB first; remaining low bits stay zero.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [SAMPLE_W-1:0] sample);
        logic [FRAME_BITS-1:0] frame;
        frame = '0;
        frame[FRAME_BITS-1-LEAD_ZEROS -: SAMPLE_W] = sample;
        return frame;
    endfunction

endpackage

// File: rtl/spi_adc_slave_if.sv
// SPI pin bundle between the ADC emulator and its master.
interface spi_adc_slave_if;

    logic cs_n;
    logic sclk;
    logic sdata;

    modport master (output cs_n, output sclk, input sdata);
    modport slave  (input cs_n, input sclk, output sdata);

endinterface

// File: rtl/spi_adc_slave_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus edge ticks derived
// from the synchronised level and its one-cycle-delayed copy.
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next-state for the synchroniser chain and the edge-history register.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Pins idle high, so reset to the idle level to avoid a phantom edge after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_adc_slave.sv
// SPI responder emulating an 8-bit serial ADC: serves the held sample in a
// 16-bit frame on sdata, clocked entirely from the system clock domain.
module spi_adc_slave
    import spi_adc_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic [SAMPLE_W-1:0] din,
    input  logic                wren,
    spi_adc_slave_if.slave      bus,
    output logic                busy,
    output logic                done,
    output logic                frame_err
);

    localparam logic [CNT_W-1:0] LAST_RISE = CNT_W'(FRAME_BITS - 1);

    logic cs_rise, cs_fall;
    logic sclk_rise, sclk_fall;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0]   hold_q, hold_d;
    logic                  sdata_q, sdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (bus.cs_n),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_sclk_sync (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (bus.sclk),
        .rise     (sclk_rise),
        .fall     (sclk_fall)
    );

    // Frame FSM next state: loads on cs fall, shifts on sclk falls, counts sclk rises.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        sdata_d = sdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // A write coinciding with the cs fall lands here; the frame below uses hold_q,
        // so the new value only serves the following frame.
        hold_d  = wren ? din : hold_q;

        case (state_q)
            IDLE: begin
                sdata_d = 1'b0;
                busy_d  = 1'b0;
                if (cs_fall) begin
                    shift_d = build_frame(hold_q);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    err_d   = 1'b1;
                    sdata_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    if (sclk_fall) begin
                        sdata_d = shift_q[FRAME_BITS-1];
                        shift_d = shift_q << 1;
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_RISE) begin
                            sdata_d = 1'b0;
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                sdata_d = 1'b0;
                if (cs_rise) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                sdata_d = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Shift register is always reloaded on cs fall before use, so it needs no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.sdata = sdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = err_q;

endmodule
